// File: rtl/alu_cmd_seq_pkg.sv
// Shared types for the ALU command sequencer: opcode and FSM state enums,
// response entry layout and an opcode legality helper.
package tb_pkg;

  localparam int OP_W   = 3;
  localparam int DATA_W = 8;
  localparam int ID_W   = 4;

  typedef enum logic [OP_W-1:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    DIV = 3'd3,
    MOD = 3'd4
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  // One FIFO entry: 13 bits, {err, id, data}
  typedef struct packed {
    logic              err;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } rsp_t;

  // Opcodes above MOD have no ALU meaning and are answered with an error
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op <= MOD);
  endfunction

endpackage

// File: rtl/alu_cmd_seq_rsp_fifo.sv
// Response FIFO for alu_cmd_seq: power-of-two depth, first-word fall-through
// head, simultaneous push/pop keeps the occupancy unchanged.
module alu_rsp_fifo
  import tb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic push,
  input  rsp_t push_data,
  input  logic pop,
  output rsp_t head,
  output logic valid,
  output logic full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  rsp_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  // Guard against overflow/underflow so the pointers can never drift
  always_comb begin
    full    = (count_reg == CNT_W'(DEPTH));
    valid   = (count_reg != '0);
    do_push = push && !full;
    do_pop  = pop && valid;
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head = mem[rd_ptr_reg];

endmodule

// File: rtl/alu_cmd_seq.sv
// ALU command sequencer: accepts one command at a time, drives an external
// fixed-latency ALU, and queues {err, id, data} responses in order.
// Optional feature macro: ALU_SEQ_DIVZERO_CHECK_EN -- answer DIV/MOD by zero
// locally with data 8'hFF, err=1 and no ALU issue.
module alu_cmd_seq
  import tb_pkg::*;
#(
  parameter int ALU_LAT   = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  // command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ID_W-1:0]   cmd_id,
  // ALU drive side
  output logic              alu_start,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_mode,
  input  logic [DATA_W-1:0] alu_c,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ID_W-1:0]   rsp_id,
  output logic              rsp_err,
  // status
  output logic              busy
);

  // WAIT holds ALU_LAT-1 cycles; the counter is loaded in ISSUE with one less
  // because the last WAIT cycle is the one where it reads zero.
  localparam logic [2:0] WAIT_LOAD = (ALU_LAT > 1) ? 3'(ALU_LAT - 2) : 3'd0;

  state_t            state_reg;
  state_t            state_next;
  logic [2:0]        wait_cnt_reg;
  logic [ID_W-1:0]   id_reg;
  logic              bypass_reg;
  logic [DATA_W-1:0] bypass_data_reg;

  logic              accept;
  logic              bypass;
  logic [DATA_W-1:0] bypass_data;
  logic              fifo_full;
  logic              fifo_valid;
  logic              push;
  rsp_t              push_data;
  rsp_t              head;

  // Commands that never reach the ALU: illegal opcodes and, optionally,
  // division by zero. These go straight to CAPTURE with a canned result.
  always_comb begin
    bypass      = 1'b0;
    bypass_data = '0;
    if (!op_legal(cmd_op)) begin
      bypass      = 1'b1;
      bypass_data = 8'h00;
    end
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    else if ((cmd_op == DIV || cmd_op == MOD) && cmd_b == '0) begin
      bypass      = 1'b1;
      bypass_data = 8'hFF;
    end
`endif
  end

  assign accept = cmd_valid && cmd_ready;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = bypass ? CAPTURE : ISSUE;
      ISSUE:   state_next = (ALU_LAT == 1) ? CAPTURE : WAIT;
      WAIT:    if (wait_cnt_reg == 3'd0) state_next = CAPTURE;
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM-decoded outputs; cmd_ready also waits for FIFO room so the single
  // in-flight command always has a slot when it reaches CAPTURE.
  always_comb begin
    alu_start = (state_reg == ISSUE);
    busy      = (state_reg != IDLE);
    cmd_ready = (state_reg == IDLE) && !fifo_full;
    push      = (state_reg == CAPTURE);
  end

  // WAIT-state down-counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_reg <= 3'd0;
    end else if (state_reg == ISSUE) begin
      wait_cnt_reg <= WAIT_LOAD;
    end else if (state_reg == WAIT && wait_cnt_reg != 3'd0) begin
      wait_cnt_reg <= wait_cnt_reg - 3'd1;
    end
  end

  // Command latch; ALU operands only change on a command that will be issued
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_reg          <= '0;
      bypass_reg      <= 1'b0;
      bypass_data_reg <= '0;
      alu_a           <= '0;
      alu_b           <= '0;
      alu_mode        <= ADD;
    end else if (accept) begin
      id_reg          <= cmd_id;
      bypass_reg      <= bypass;
      bypass_data_reg <= bypass_data;
      if (!bypass) begin
        alu_a    <= cmd_a;
        alu_b    <= cmd_b;
        alu_mode <= cmd_op;
      end
    end
  end

  // ALU results pass through untouched; bypassed commands carry err=1
  always_comb begin
    push_data.id = id_reg;
    if (bypass_reg) begin
      push_data.err  = 1'b1;
      push_data.data = bypass_data_reg;
    end else begin
      push_data.err  = 1'b0;
      push_data.data = alu_c;
    end
  end

  alu_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (rsp_ready),
    .head      (head),
    .valid     (fifo_valid),
    .full      (fifo_full)
  );

  assign rsp_valid = fifo_valid;
  assign rsp_data  = head.data;
  assign rsp_id    = head.id;
  assign rsp_err   = head.err;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Self-checking bench for alu_cmd_seq: directed scenarios plus randomized
// traffic scored against a queue-based reference model.
module tb_alu_cmd_seq;
  import tb_pkg::*;

  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic [2:0] cmd_op = '0;
  logic [3:0] cmd_id = '0;
  logic       alu_start;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_mode;
  logic [7:0] alu_c;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [3:0] rsp_id;
  logic       rsp_err;
  logic       busy;

  logic ready_force = 1'b1;
  logic rand_mode = 1'b0;
  logic rand_bit = 1'b1;
  assign rsp_ready = rand_mode ? rand_bit : ready_force;

  int checks = 0;
  int failures = 0;
  int starts_seen = 0;
  int starts_exp = 0;
  int pops_seen = 0;
  logic [12:0] exp_q[$];

  always #5 clock = ~clock;

  alu_cmd_seq #(.ALU_LAT(LAT), .RSP_DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_op(cmd_op), .cmd_id(cmd_id),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    if (obs !== expd) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expd);
    end
  endtask

  // Bench ALU: result appears LAT edges after the start pulse, junk otherwise
  function automatic logic [7:0] alu_fn(input logic [7:0] a, b, input logic [2:0] m);
    case (m)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a * b;
      3'd3: return (b == 0) ? 8'hFF : a / b;
      3'd4: return (b == 0) ? a : a % b;
      default: return 8'h00;
    endcase
  endfunction

  logic [7:0] alu_pipe [LAT];
  always @(posedge clock) begin
    alu_pipe[0] <= alu_start ? alu_fn(alu_a, alu_b, alu_mode) : 8'($urandom);
    for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    rand_bit <= ($urandom_range(0, 3) != 0);
  end
  assign alu_c = alu_pipe[LAT-1];

  // Reference: expected response of a command, from the opcode rules
  function automatic logic [12:0] ref_rsp(input logic [7:0] a, b, input logic [2:0] op,
                                          input logic [3:0] id);
    int r;
    if (op > 3'd4) return {1'b1, id, 8'h00};
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    if ((op == 3'd3 || op == 3'd4) && b == 0) return {1'b1, id, 8'hFF};
`endif
    r = 0;
    if (op == 3'd0) r = int'(a) + int'(b);
    else if (op == 3'd1) r = int'(a) - int'(b);
    else if (op == 3'd2) r = int'(a) * int'(b);
    else if (op == 3'd3) r = (b == 0) ? 255 : int'(a) / int'(b);
    else r = (b == 0) ? int'(a) : int'(a) % int'(b);
    return {1'b0, id, r[7:0]};
  endfunction

  function automatic bit ref_starts(input logic [7:0] b, input logic [2:0] op);
    if (op > 3'd4) return 1'b0;
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    if ((op == 3'd3 || op == 3'd4) && b == 0) return 1'b0;
`endif
    return 1'b1;
  endfunction

  // Scoreboard: handshakes are sampled at negedge, they complete on the next posedge
  logic [12:0] e;
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      if (alu_start) starts_seen++;
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back(ref_rsp(cmd_a, cmd_b, cmd_op, cmd_id));
        if (ref_starts(cmd_b, cmd_op)) starts_exp++;
      end
      if (rsp_valid && rsp_ready) begin
        pops_seen++;
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("rsp id=%0d data=0x%02h err=%0b (exp id=%0d data=0x%02h err=%0b)",
                   rsp_id, rsp_data, rsp_err, e[11:8], e[7:0], e[12]);
          check("rsp_data", 32'(rsp_data), 32'(e[7:0]));
          check("rsp_id", 32'(rsp_id), 32'(e[11:8]));
          check("rsp_err", 32'(rsp_err), 32'(e[12]));
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] a, b, input logic [2:0] op, input logic [3:0] id);
    bit done;
    done = 1'b0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_id = id; cmd_valid = 1'b1;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clock);
      if (cmd_ready) done = 1'b1;
      @(posedge clock);
      #1;
    end
    cmd_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clock);
      if (!busy) done = 1'b1;
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [2:0] op;
    logic [7:0] b;

    // Reset state
    cycles(3);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_start", 32'(alu_start), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_mode", 32'(alu_mode), 32'(ADD));
    @(negedge clock);
    reset_n = 1'b1;
    cycles(1);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // ADD 200+100 id 3: start pulse, operand hold and accept-to-push latency
    ready_force = 1'b1;
    send(8'd200, 8'd100, ADD, 4'd3);
    for (int j = 0; j <= LAT + 1; j++) begin
      @(negedge clock);
      $display("lat j=%0d start=%0b busy=%0b rsp_valid=%0b", j, alu_start, busy, rsp_valid);
      check("lat_alu_start", 32'(alu_start), 32'(j == 0));
      check("lat_busy", 32'(busy), 32'(j <= LAT));
      check("lat_rsp_valid", 32'(rsp_valid), 32'(j == LAT + 1));
      if (j <= LAT) begin
        check("hold_alu_a", 32'(alu_a), 32'd200);
        check("hold_alu_b", 32'(alu_b), 32'd100);
      end else begin
        check("add_data", 32'(rsp_data), 32'd44);
        check("add_id", 32'(rsp_id), 32'd3);
        check("add_err", 32'(rsp_err), 32'd0);
      end
    end
    cycles(1);
    drain();

    // Back-to-back SUB/MUL, illegal opcode
    send(8'd5, 8'd7, SUB, 4'd1);
    send(8'd16, 8'd17, MUL, 4'd2);
    send(8'd9, 8'd3, 3'd6, 4'd5);
    drain();

    // DIV by zero
    base = starts_seen;
    send(8'd7, 8'd0, DIV, 4'd4);
    drain();
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    check("div0_starts", 32'(starts_seen - base), 32'd0);
`else
    check("div0_starts", 32'(starts_seen - base), 32'd1);
`endif

    // Backpressure: four responses fill the FIFO, fifth waits
    ready_force = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(i * 10), 8'(i), ADD, 4'(8 + i));
    wait_idle();
    cycles(5);
    @(negedge clock);
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    check("full_rsp_valid", 32'(rsp_valid), 32'd1);
    cycles(1);
    ready_force = 1'b1;
    send(8'd33, 8'd11, SUB, 4'd12);
    drain();

    // Push and pop on the same edge with two entries queued
    ready_force = 1'b0;
    send(8'd1, 8'd2, ADD, 4'd1);
    send(8'd3, 8'd4, MUL, 4'd2);
    wait_idle();
    send(8'd100, 8'd7, MOD, 4'd3);
    cycles(LAT);
    ready_force = 1'b1;
    cycles(1);
    ready_force = 1'b0;
    base = pops_seen;
    @(negedge clock);
    check("simul_rsp_valid", 32'(rsp_valid), 32'd1);
    cycles(1);
    ready_force = 1'b1;
    drain();
    check("simul_remaining_pops", 32'(pops_seen - base), 32'd2);

    // Reset during WAIT discards the in-flight command and the queue
    ready_force = 1'b0;
    send(8'd9, 8'd9, ADD, 4'd1);
    wait_idle();
    send(8'd50, 8'd60, ADD, 4'd2);
    @(negedge clock);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("wait_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("wait_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    ready_force = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clock);
      check("no_stale_rsp", 32'(rsp_valid), 32'd0);
    end
    cycles(1);
    send(8'd1, 8'd1, ADD, 4'd7);
    drain();

    // Randomized traffic with random response backpressure
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7));
      b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      send(8'($urandom), b, op, 4'($urandom));
      if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 3));
    end
    drain();
    rand_mode = 1'b0;
    ready_force = 1'b1;

    check("start_count", 32'(starts_seen), 32'(starts_exp));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_seq.md
ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 The block SHALL have parameter ALU_LAT, default 1, giving the ALU edges from operands presented to alu_c valid (legal range 1..7).
REQ-002 The block SHALL have parameter RSP_DEPTH, default 4, giving the response FIFO entries (power of two, 2..16).
REQ-003 The block SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports cmd_valid (input, 1), cmd_ready (output, 1), cmd_a (input, 8), cmd_b (input, 8), cmd_op (input, opcode), cmd_id (input, 4): the command channel.
REQ-006 The block SHALL have ports alu_start (output, 1), alu_a (output, 8), alu_b (output, 8), alu_mode (output, opcode), alu_c (input, 8): the ALU drive side.
REQ-007 The block SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_data (output, 8), rsp_id (output, 4), rsp_err (output, 1): the response channel.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever the FSM state is not IDLE.

Function
REQ-009 FSM states SHALL be IDLE, ISSUE, WAIT and CAPTURE.
REQ-010 cmd_ready SHALL be 1 only when the state is IDLE and the FIFO count is below RSP_DEPTH.
REQ-011 A command SHALL be accepted on the edge where cmd_valid and cmd_ready are both 1; the block latches a, b, op and id, and the FSM moves IDLE->ISSUE.
REQ-012 In ISSUE, alu_start SHALL be 1 for exactly one cycle; the FSM then moves to WAIT.
REQ-013 alu_a, alu_b and alu_mode SHALL be registered and held stable from ISSUE until the FSM returns to IDLE.
REQ-014 WAIT SHALL last ALU_LAT-1 cycles (zero cycles when ALU_LAT=1), counted by a 3-bit down-counter; the FSM then moves to CAPTURE.
REQ-015 In CAPTURE, alu_c SHALL be pushed into the FIFO with the latched id and err=0, and the FSM returns to IDLE.
REQ-016 Accept-to-push latency SHALL be ALU_LAT+1 edges, and at most one command SHALL be in flight.
REQ-017 The FIFO SHALL present its head on rsp_data, rsp_id and rsp_err, with rsp_valid = (count != 0).
REQ-018 A pop SHALL occur on the edge where rsp_valid and rsp_ready are both 1.
REQ-019 A push and a pop on the same edge SHALL leave the count unchanged; pointers SHALL wrap modulo RSP_DEPTH.
REQ-020 Responses SHALL be returned in acceptance order.
REQ-021 Results SHALL be taken unmodified from alu_c as 8-bit values: no widening, sign handling or saturation.
REQ-022 An opcode outside ADD, SUB, MUL, DIV and MOD SHALL produce a response with err=1 and data 8'h00, with no alu_start.

Reset
REQ-023 Asserting reset_n low SHALL asynchronously force state IDLE, empty the FIFO, and drive alu_start=0, alu_a=0, alu_b=0, alu_mode=ADD, rsp_valid=0 and busy=0.
REQ-024 Reset during ISSUE, WAIT or CAPTURE SHALL discard the in-flight command with no response produced.
REQ-025 cmd_ready SHALL be 1 on the first edge after reset_n rises.

Configuration
REQ-026 With macro ALU_SEQ_DIVZERO_CHECK_EN defined, a DIV or MOD command with b==0 SHALL skip ISSUE/WAIT, push data 8'hFF with err=1 on the next edge, and never assert alu_start.
REQ-027 Without ALU_SEQ_DIVZERO_CHECK_EN, such commands SHALL be issued normally; err is then driven only by the REQ-022 rule.

Structure
REQ-028 The opcode enum (ADD, SUB, MUL, DIV, MOD) and the FSM state enum SHALL live in the shared package tb_pkg.
REQ-029 The response storage SHALL be the sub-module alu_rsp_fifo (synchronous, parameterised depth, 13-bit entries {err, id, data}).

Verification
REQ-030 ADD with a=200, b=100, id=3, ALU_LAT=1 -> one alu_start pulse, then rsp_data=8'd44, rsp_id=3, rsp_err=0, pushed 2 edges after accept.
REQ-031 Back-to-back SUB 5-7 (id 1) and MUL 16*17 (id 2) -> responses 8'hFE then 8'd16 in id order.
REQ-032 With rsp_ready=0, issue 5 commands -> cmd_ready stays 0 after the 4th push; raise rsp_ready -> 4 responses in order, then the 5th is accepted.
REQ-033 DIV 7/0 with the macro defined -> no alu_start, rsp_data=8'hFF, rsp_err=1; without the macro -> alu_start pulses and rsp_err=0.
REQ-034 reset_n low during WAIT (ALU_LAT=3) -> rsp_valid=0 and busy=0 immediately, no stale response after release, and the next ADD 1+1 returns 8'd2.
REQ-035 Simultaneous push and pop with count=2 -> count remains 2 and order is preserved.
